// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD minimum tracker.
package sad_pkg;

  localparam int SAD_W = 32;
  localparam logic [SAD_W-1:0] SAD_INIT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    CMP   = 2'd2,
    DONE  = 2'd3
  } sad_state_e;

endpackage

// File: rtl/sad_fall_det.sv
// Falling-edge detector for the upstream SAD engine busy flag.
module sad_fall_det (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  output logic fall
);

  logic busy_q;

  always_ff @(posedge clk) begin
    if (rst) busy_q <= 1'b0;
    else     busy_q <= busy;
  end

  assign fall = busy_q & ~busy;

endmodule

// File: rtl/sad_min_tracker.sv
// Tracks the minimum SAD (and its candidate index) over NCAND upstream results.
// Optional early exit on a good-enough match: define SAD_MIN_EARLY_EXIT_EN.
module sad_min_tracker
  import sad_pkg::*;
#(
  parameter int NCAND = 16,
  parameter int IDXW  = 8
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             busy_i,
  input  logic [31:0]      sad_i,
`ifdef SAD_MIN_EARLY_EXIT_EN
  input  logic [31:0]      thresh_i,
  output logic             early_o,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      best_sad_o,
  output logic [IDXW-1:0]  best_idx_o,
  output logic [IDXW:0]    cnt_o
);

  localparam logic [IDXW:0] NCAND_C = (IDXW+1)'(NCAND);

  sad_state_e       state;
  logic [SAD_W-1:0] captured;
  logic [SAD_W-1:0] best_sad;
  logic [IDXW-1:0]  best_idx;
  logic [IDXW:0]    cnt;
  logic [IDXW:0]    cnt_nxt;
  logic             fall;
  logic             better;
  logic             full;
  logic             early_hit;

  sad_fall_det u_fall (
    .clk  (clk),
    .rst  (rst_i),
    .busy (busy_i),
    .fall (fall)
  );

  // Strict compare: ties and all-ones results never displace the current best.
  assign better  = captured < best_sad;
  assign cnt_nxt = (cnt < NCAND_C) ? cnt + 1'b1 : cnt;
  assign full    = cnt_nxt >= NCAND_C;

`ifdef SAD_MIN_EARLY_EXIT_EN
  logic early_q;
  assign early_hit = captured <= thresh_i;
  assign early_o   = done_o & early_q;
`else
  assign early_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state    <= IDLE;
      captured <= SAD_INIT;
      best_sad <= SAD_INIT;
      best_idx <= '0;
      cnt      <= '0;
`ifdef SAD_MIN_EARLY_EXIT_EN
      early_q  <= 1'b0;
`endif
    end else if (start_i) begin
      // Also restarts an in-flight search; a coincident fall event is dropped.
      state    <= TRACK;
      best_sad <= SAD_INIT;
      best_idx <= '0;
      cnt      <= '0;
`ifdef SAD_MIN_EARLY_EXIT_EN
      early_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: ;
        TRACK: begin
          if (fall) begin
            captured <= sad_i;
            state    <= CMP;
          end
        end
        CMP: begin
          if (better) begin
            best_sad <= captured;
            best_idx <= cnt[IDXW-1:0];
          end
          cnt   <= cnt_nxt;
          state <= (full || early_hit) ? DONE : TRACK;
`ifdef SAD_MIN_EARLY_EXIT_EN
          early_q <= early_hit & ~full;
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o     = state != IDLE;
  assign done_o     = state == DONE;
  assign best_sad_o = best_sad;
  assign best_idx_o = best_idx;
  assign cnt_o      = cnt;

endmodule

// File: doc/sad_min_tracker.md
SAD_MIN_TRACKER -- requirements
Module: sad_min_tracker

Interface
REQ-001 SHALL have parameter NCAND, default 16, meaning the number of SAD results per search (legal range 2..256).
REQ-002 SHALL have parameter IDXW, default 8, meaning the width of the candidate index.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start_i, input, 1 bit: one-cycle pulse that begins a new search.
REQ-006 SHALL have port busy_i, input, 1 bit: the upstream SAD engine busy flag.
REQ-007 SHALL have port sad_i, input, 32 bits: the upstream SAD result, valid in the cycle busy_i falls.
REQ-008 SHALL have port busy_o, output, 1 bit: high while a search is in progress.
REQ-009 SHALL have port done_o, output, 1 bit: one-cycle pulse when the search completes.
REQ-010 SHALL have port best_sad_o, output, 32 bits: the minimum SAD of the search.
REQ-011 SHALL have port best_idx_o, output, IDXW bits: the candidate index of the minimum.
REQ-012 SHALL have port cnt_o, output, IDXW+1 bits: the number of results captured in the current search.

Function
REQ-013 SHALL use FSM states IDLE, TRACK, CMP, DONE.
- IDLE->TRACK on start_i.
- TRACK->CMP on a busy_i falling edge.
- CMP->TRACK if cnt < NCAND, else CMP->DONE.
- DONE->IDLE after exactly one cycle.
REQ-014 SHALL register busy_i into busy_q and define a fall event as busy_q & ~busy_i.
- sad_i SHALL be latched in that same cycle.
REQ-015 SHALL ignore fall events in IDLE and DONE.
- A fall event in the same cycle as start_i SHALL also be ignored.
REQ-016 On start_i, the block SHALL set best_sad to 32'hFFFF_FFFF, best_idx to 0 and cnt to 0.
REQ-017 In CMP, the block SHALL replace best_sad/best_idx when captured < best_sad (strict less), so ties keep the earliest index.
- The block SHALL then increment cnt.
REQ-018 The captured index SHALL equal the value of cnt before the increment (0-based).
REQ-019 done_o SHALL assert in the DONE state, 2 cycles after the NCAND-th fall event.
- best_sad_o/best_idx_o SHALL hold final values from that cycle until the next start_i.
REQ-020 busy_o SHALL be high in TRACK, CMP and DONE, and low in IDLE.
REQ-021 start_i while busy_o is high SHALL restart the search (REQ-016) and SHALL NOT assert done_o for the aborted search.
REQ-022 A captured value of 32'hFFFF_FFFF SHALL NOT replace the initial best.
- If all results are all-ones, best_idx_o SHALL be 0.
REQ-023 cnt SHALL saturate at NCAND and never wrap.

Reset
REQ-024 While rst_i is high at a clock edge, the block SHALL go to IDLE and set busy_q=0.
- Outputs SHALL reset to: busy_o=0, done_o=0, best_sad_o=32'hFFFF_FFFF, best_idx_o=0, cnt_o=0.
REQ-025 Reset asserted mid-search SHALL abort the search without a done_o pulse.
- rst_i SHALL take priority over start_i.

Configuration
REQ-026 Macro SAD_MIN_EARLY_EXIT_EN SHALL control an early-exit feature.
- When defined: add input thresh_i (32 bits); in CMP, captured <= thresh_i SHALL force CMP->DONE regardless of cnt, and add output early_o (1 bit) high with done_o when exit was early.
- When not defined: no thresh_i or early_o ports, and the search always runs NCAND results.

Structure
REQ-027 A package sad_pkg SHALL hold the FSM state enum, the SAD_W=32 constant and SAD_INIT=32'hFFFF_FFFF.
REQ-028 The busy_i falling-edge detector SHALL be a sub-module named sad_fall_det; all other logic is in sad_min_tracker.

Verification
REQ-029 Bench SHALL cover the following directed scenarios:
- NCAND=4, results 50,20,30,40 -> done_o once; best_sad_o=20, best_idx_o=1, cnt_o=4.
- NCAND=4, results 7,7,9,7 -> best_idx_o=0 (tie keeps earliest), best_sad_o=7.
- start_i after 2 of 4 results, then 5,6,1,8 -> no done_o for the aborted search; best_sad_o=1, best_idx_o=2.
- rst_i high after 3 of 4 results -> next cycle busy_o=0, cnt_o=0, best_sad_o=FFFF_FFFF; no done_o.
- Macro defined, thresh_i=10, results 40,8,… -> done_o and early_o 2 cycles after the 2nd fall; best_idx_o=1, cnt_o=2.
- busy_i glitch (high 1 cycle) in IDLE -> no capture; cnt_o stays 0.
